// File: rtl/onfi_wb_master.sv
// Request/response front end driving a single-outstanding Wishbone classic initiator.
// Define ONFI_WB_TIMEOUT_EN to add a bus watchdog that ends stalled cycles with rsp_tmo_o.
module onfi_wb_master #(
    parameter int MM_DATA_W      = 32,
    parameter int MM_ADDR_W      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 mm_clk_i,
    input  logic                 mm_rst_n_i,

    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [MM_ADDR_W-1:0] req_addr_i,
    input  logic [MM_DATA_W-1:0] req_dat_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [MM_DATA_W-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 rsp_tmo_o,

    output logic                 mm_cyc_o,
    output logic                 mm_stb_o,
    output logic                 mm_we_o,
    output logic [MM_ADDR_W-1:0] mm_addr_o,
    output logic [MM_DATA_W-1:0] mm_dat_o,
    input  logic [MM_DATA_W-1:0] mm_dat_i,
    input  logic                 mm_ack_i,
    input  logic                 mm_err_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("onfi_wb_master: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [MM_ADDR_W-1:0]   addr_q, addr_d;
    logic [MM_DATA_W-1:0]   wdat_q, wdat_d;
    logic [MM_DATA_W-1:0]   rdat_q, rdat_d;
    logic                   err_q, err_d;

`ifdef ONFI_WB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic                   tmo_q, tmo_d;
    logic [7:0]             cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
`ifdef ONFI_WB_TIMEOUT_EN
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d = BUS;
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdat_d  = req_we_i ? req_dat_i : '0;
                    rdat_d  = '0;
                    err_d   = 1'b0;
`ifdef ONFI_WB_TIMEOUT_EN
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                // An error outranks a simultaneous ack, and either outranks watchdog expiry.
                if (mm_err_i) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                end else if (mm_ack_i) begin
                    state_d = RESP;
                    rdat_d  = we_q ? '0 : mm_dat_i;
                end
`ifdef ONFI_WB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    tmo_d   = 1'b1;
                    rdat_d  = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        cyc_d   = (state_d == BUS);
    end

    // Ready is registered so it stays low for the whole reset and rises one edge after release.
    always_ff @(posedge mm_clk_i) begin
        if (!mm_rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
`ifdef ONFI_WB_TIMEOUT_EN
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
`ifdef ONFI_WB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_dat_o   = rdat_q;
    assign rsp_err_o   = err_q;
`ifdef ONFI_WB_TIMEOUT_EN
    assign rsp_tmo_o   = tmo_q;
`else
    assign rsp_tmo_o   = 1'b0;
`endif

    assign mm_cyc_o    = cyc_q;
    assign mm_stb_o    = cyc_q;
    assign mm_we_o     = we_q;
    assign mm_addr_o   = addr_q;
    assign mm_dat_o    = wdat_q;

endmodule

// File: tb/tb_onfi_wb_master.sv
// Bench for onfi_wb_master: vector table, hand-written corner sequences and a randomized run
// against a register-slave reference model; timeout checks follow ONFI_WB_TIMEOUT_EN.
module tb_onfi_wb_master;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          mm_clk_i = 1'b0;
    logic          mm_rst_n_i;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_dat;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [DW-1:0] rsp_dat;
    logic          mm_cyc_o, mm_stb_o, mm_we_o;
    logic [AW-1:0] mm_addr_o;
    logic [DW-1:0] mm_dat_o, mm_dat_i;
    logic          mm_ack_i, mm_err_i;

    int total = 0;
    int bad   = 0;

    always #5 mm_clk_i = ~mm_clk_i;

    onfi_wb_master #(.MM_DATA_W(DW), .MM_ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .mm_clk_i   (mm_clk_i),
        .mm_rst_n_i (mm_rst_n_i),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_dat_i  (req_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .mm_cyc_o   (mm_cyc_o),
        .mm_stb_o   (mm_stb_o),
        .mm_we_o    (mm_we_o),
        .mm_addr_o  (mm_addr_o),
        .mm_dat_o   (mm_dat_o),
        .mm_dat_i   (mm_dat_i),
        .mm_ack_i   (mm_ack_i),
        .mm_err_i   (mm_err_i)
    );

    // Register slave: mode 0 acks after slv_delay cycles, mode 1 raises err+ack, mode 2 never answers.
    int            slv_mode  = 0;
    int            slv_delay = 0;
    int            slv_wait  = 0;
    logic          spur      = 1'b0;
    logic          slv_ack, slv_err;
    logic [DW-1:0] slv_rdata;
    logic [DW-1:0] slv_mem [0:255];
    logic          slv_written [0:255] = '{default: 1'b0};

    always_comb begin
        slv_ack   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = 32'h0;
        if (mm_cyc_o && mm_stb_o && slv_wait >= slv_delay) begin
            if (slv_mode == 0) begin
                slv_ack   = 1'b1;
                slv_rdata = slv_written[mm_addr_o] ? slv_mem[mm_addr_o]
                          : ((mm_addr_o == 8'h00) ? 32'hDEADDEAD : 32'h0);
            end else if (slv_mode == 1) begin
                slv_ack   = 1'b1;
                slv_err   = 1'b1;
                slv_rdata = 32'h12345678;
            end
        end
    end

    assign mm_dat_i = slv_rdata;
    assign mm_ack_i = slv_ack | (spur & ~mm_cyc_o);
    assign mm_err_i = slv_err | (spur & ~mm_cyc_o);

    always @(posedge mm_clk_i) begin
        slv_wait <= mm_cyc_o ? slv_wait + 1 : 0;
        if (slv_ack && !slv_err && mm_we_o) begin
            slv_mem[mm_addr_o]     <= mm_dat_o;
            slv_written[mm_addr_o] <= 1'b1;
        end
    end

    // Reference model: the slave's contents as implied by every acknowledged write so far.
    logic [DW-1:0] model_mem [int];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return (a == 8'h00) ? 32'hDEADDEAD : 32'h0;
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        int            mode;
        int            delay;
        int            hold;
        logic [DW-1:0] exp_dat;
        logic          exp_err;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                                 input int mode, input int delay, input int hold,
                                 output logic [DW-1:0] got_dat, output logic got_err, output logic got_tmo,
                                 output int cyc_cnt, output int lat, output logic hold_ok, output logic bus_ok);
        int waited = 0;
        slv_mode  = mode;
        slv_delay = delay;
        req_we    = we;
        req_addr  = addr;
        req_dat   = dat;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        while (!req_ready && waited < 50) begin
            @(negedge mm_clk_i);
            waited++;
        end
        @(negedge mm_clk_i);
        req_valid = 1'b0;
        cyc_cnt = 0;
        lat     = 0;
        bus_ok  = (waited < 50);
        hold_ok = 1'b1;
        got_dat = '0;
        got_err = 1'b0;
        got_tmo = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (mm_cyc_o) begin
                cyc_cnt++;
                if (mm_stb_o !== 1'b1 || mm_we_o !== we || mm_addr_o !== addr ||
                    mm_dat_o !== (we ? dat : 32'h0)) bus_ok = 1'b0;
            end else if (mm_stb_o !== 1'b0) begin
                bus_ok = 1'b0;
            end
            if (rsp_valid) begin
                lat = n;
                if (mm_cyc_o) bus_ok = 1'b0;
                break;
            end
            @(negedge mm_clk_i);
        end
        if (lat != 0) begin
            got_dat = rsp_dat;
            got_err = rsp_err;
            got_tmo = rsp_tmo;
            repeat (hold) begin
                @(negedge mm_clk_i);
                if (rsp_valid !== 1'b1 || rsp_dat !== got_dat || rsp_err !== got_err ||
                    rsp_tmo !== got_tmo || req_ready !== 1'b0 || mm_cyc_o !== 1'b0) hold_ok = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge mm_clk_i);
            rsp_ready = 1'b0;
            if (rsp_valid !== 1'b0 || mm_cyc_o !== 1'b0) hold_ok = 1'b0;
        end
    endtask

    task automatic run_and_check(input string tag, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] dat, input int mode, input int delay, input int hold,
                                 input logic [DW-1:0] exp_dat, input logic exp_err, input logic exp_tmo,
                                 input int exp_cyc);
        logic [DW-1:0] got_dat;
        logic          got_err, got_tmo, hold_ok, bus_ok;
        int            cyc_cnt, lat;
        applyStimulus(we, addr, dat, mode, delay, hold, got_dat, got_err, got_tmo, cyc_cnt, lat, hold_ok, bus_ok);
        checkOutput({tag, "_dat"}, got_dat, exp_dat);
        checkOutput({tag, "_err"}, 32'(got_err), 32'(exp_err));
        checkOutput({tag, "_tmo"}, 32'(got_tmo), 32'(exp_tmo));
        checkOutput({tag, "_cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
        checkOutput({tag, "_rsp_latency"}, 32'(lat), 32'(exp_cyc + 1));
        checkOutput({tag, "_rsp_hold"}, 32'(hold_ok), 32'd1);
        checkOutput({tag, "_bus_signals"}, 32'(bus_ok), 32'd1);
    endtask

    task automatic start_silent_req(input logic [AW-1:0] addr);
        int waited = 0;
        slv_mode  = 2;
        req_we    = 1'b0;
        req_addr  = addr;
        req_dat   = 32'h0;
        req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            @(negedge mm_clk_i);
            waited++;
        end
        checkOutput("silent_accept", 32'(waited < 50), 32'd1);
        @(negedge mm_clk_i);
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic          ok;
        int            first, second, low;
        logic          r_we;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_dat, r_exp;
        int            r_mode, r_delay, r_hold;

        vecs[0] = '{1'b1, 8'h04, 32'hA5A55A5A, 0, 1, 0, 32'h0,        1'b0, 2};
        vecs[1] = '{1'b0, 8'h04, 32'h0,        0, 1, 0, 32'hA5A55A5A, 1'b0, 2};
        vecs[2] = '{1'b0, 8'h00, 32'h0,        0, 1, 0, 32'hDEADDEAD, 1'b0, 2};
        vecs[3] = '{1'b0, 8'h10, 32'h0,        1, 0, 0, 32'h0,        1'b1, 1};
        vecs[4] = '{1'b1, 8'h20, 32'h11223344, 0, 3, 0, 32'h0,        1'b0, 4};
        vecs[5] = '{1'b0, 8'h20, 32'h0,        0, 0, 5, 32'h11223344, 1'b0, 1};
        vecs[6] = '{1'b1, 8'h30, 32'hCAFEF00D, 1, 2, 1, 32'h0,        1'b1, 3};
        vecs[7] = '{1'b0, 8'h30, 32'h0,        0, 0, 0, 32'h0,        1'b0, 1};

        mm_rst_n_i = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_dat    = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge mm_clk_i);
        checkOutput("rst_cyc",       32'(mm_cyc_o),  32'd0);
        checkOutput("rst_stb",       32'(mm_stb_o),  32'd0);
        checkOutput("rst_we",        32'(mm_we_o),   32'd0);
        checkOutput("rst_addr",      32'(mm_addr_o), 32'd0);
        checkOutput("rst_wdat",      mm_dat_o,       32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
        checkOutput("rst_rsp_tmo",   32'(rsp_tmo),   32'd0);
        checkOutput("rst_rsp_dat",   rsp_dat,        32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        mm_rst_n_i = 1'b1;
        @(negedge mm_clk_i);
        checkOutput("rel_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].dat, vecs[i].mode,
                          vecs[i].delay, vecs[i].hold, vecs[i].exp_dat, vecs[i].exp_err, 1'b0, vecs[i].exp_cyc);
            if (vecs[i].we && vecs[i].mode == 0) model_mem[int'(vecs[i].addr)] = vecs[i].dat;
        end

        // Back-to-back writes with rsp_ready tied high against a one-cycle-late slave.
        slv_mode  = 0;
        slv_delay = 1;
        req_we    = 1'b1;
        req_addr  = 8'h44;
        req_dat   = 32'h0BADF00D;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        first  = -1;
        second = -1;
        low    = 0;
        for (int k = 0; k < 20 && second < 0; k++) begin
            if (first >= 0 && !mm_cyc_o) low++;
            if (req_valid && req_ready) begin
                if (first < 0) first = k;
                else second = k;
            end
            @(negedge mm_clk_i);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge mm_clk_i);
        rsp_ready = 1'b0;
        model_mem[8'h44] = 32'h0BADF00D;
        checkOutput("turnaround", 32'(second - first), 32'd4);
        checkOutput("gap_cyc_low", 32'(low), 32'd2);

        for (int t = 0; t < 30; t++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 8'($urandom_range(0, 7) * 4);
            r_dat   = $urandom;
            r_mode  = ($urandom_range(0, 9) < 2) ? 1 : 0;
            r_delay = $urandom_range(0, 3);
            r_hold  = $urandom_range(0, 2);
            spur    = 1'($urandom_range(0, 1));
            if (r_mode == 1)  r_exp = 32'h0;
            else if (r_we)    r_exp = 32'h0;
            else              r_exp = model_read(r_addr);
            run_and_check($sformatf("rnd%0d", t), r_we, r_addr, r_dat, r_mode, r_delay, r_hold,
                          r_exp, (r_mode == 1), 1'b0, r_delay + 1);
            if (r_we && r_mode == 0) model_mem[int'(r_addr)] = r_dat;
        end
        spur = 1'b0;

`ifdef ONFI_WB_TIMEOUT_EN
        run_and_check("timeout", 1'b0, 8'h08, 32'h0, 2, 0, 0, 32'h0, 1'b0, 1'b1, TMO);
        start_silent_req(8'h0C);
        repeat (3) @(negedge mm_clk_i);
`else
        start_silent_req(8'h08);
        ok = 1'b1;
        repeat (110) begin
            if (!mm_cyc_o || !mm_stb_o || rsp_valid) ok = 1'b0;
            @(negedge mm_clk_i);
        end
        checkOutput("no_timeout_hold", 32'(ok), 32'd1);
`endif

        // One reset edge while the bus cycle is open must abandon it silently.
        mm_rst_n_i = 1'b0;
        @(negedge mm_clk_i);
        checkOutput("midrst_cyc",       32'(mm_cyc_o),  32'd0);
        checkOutput("midrst_stb",       32'(mm_stb_o),  32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
        mm_rst_n_i = 1'b1;
        slv_mode   = 0;
        @(negedge mm_clk_i);
        checkOutput("midrst_ready_back", 32'(req_ready), 32'd1);
        ok = 1'b1;
        repeat (5) begin
            if (rsp_valid || mm_cyc_o) ok = 1'b0;
            @(negedge mm_clk_i);
        end
        checkOutput("midrst_no_rsp", 32'(ok), 32'd1);
        run_and_check("post_rst", 1'b0, 8'h04, 32'h0, 0, 1, 0, model_read(8'h04), 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
